// File: rtl/pwm_bank_pkg.sv
// rtl/pwm_bank_pkg.sv - register map offsets and bit indices for pwm_bank
package pwm_bank_pkg;

    typedef logic [4:0] reg_off_t;

    localparam reg_off_t REG_DUTY0  = 5'h00;
    localparam reg_off_t REG_CTRL   = 5'h10;
    localparam reg_off_t REG_STEP   = 5'h11;
    localparam reg_off_t REG_COMMIT = 5'h12;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_INVERT  = 1;
    localparam int STAT_PENDING = 0;
    localparam int STAT_FADING  = 1;

endpackage

// File: rtl/pwm_fader.sv
// rtl/pwm_fader.sv - per-channel current duty, clamped fade step and PWM compare
module pwm_fader
    import pwm_bank_pkg::*;
#(
    parameter int PWM_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wrap,
    input  logic [PWM_WIDTH-1:0] i_step,
    input  logic [PWM_WIDTH-1:0] i_target,
    input  logic [PWM_WIDTH-1:0] i_count,
    input  logic                 i_enable,
    input  logic                 i_invert,
    output logic [PWM_WIDTH-1:0] o_current,
    output logic                 o_pwm
);

    localparam int W = PWM_WIDTH;

    logic [W-1:0] current_q, current_d;
    logic         pwm_q, pwm_d;
    logic [W:0]   up_sum;
    logic [W:0]   down_diff;

    always_comb begin
        // One extra bit so the step can never wrap past either end of the range.
        up_sum    = {1'b0, current_q} + {1'b0, i_step};
        down_diff = {1'b0, current_q} - {1'b0, i_step};
        current_d = current_q;
        if (i_wrap && (current_q != i_target)) begin
            if (i_step == '0) begin
                current_d = i_target;
            end else if (current_q < i_target) begin
                current_d = (up_sum >= {1'b0, i_target}) ? i_target : up_sum[W-1:0];
            end else begin
                current_d = (down_diff[W] || (down_diff[W-1:0] <= i_target)) ? i_target
                                                                              : down_diff[W-1:0];
            end
        end
        pwm_d = i_enable & ((i_count < current_q) ^ i_invert);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            current_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            current_q <= current_d;
            pwm_q     <= pwm_d;
        end
    end

    assign o_current = current_q;
    assign o_pwm     = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM engine with shadowed duties, fading and register window
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int                    NUM_CHANNELS = 3,
    parameter int                    PWM_WIDTH    = 16,
    parameter int                    PRESCALE     = 1,
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 8'hE0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic [15:0]             i_write_data,
    input  logic                    i_write_strobe,
    input  logic                    i_read_strobe,
    output logic [15:0]             o_read_data,
    output logic                    o_read_valid,
    output logic [NUM_CHANNELS-1:0] o_pwm,
    output logic                    o_period_strobe
);

    localparam int W    = PWM_WIDTH;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]       ps_q, ps_d;
    logic [W-1:0]          count_q, count_d;
    logic [W-1:0]          shadow_q [NUM_CHANNELS];
    logic [W-1:0]          shadow_d [NUM_CHANNELS];
    logic [W-1:0]          target_q [NUM_CHANNELS];
    logic [W-1:0]          target_d [NUM_CHANNELS];
    logic [W-1:0]          current  [NUM_CHANNELS];
    logic [W-1:0]          step_q, step_d;
    logic                  enable_q, enable_d;
    logic                  invert_q, invert_d;
    logic                  pending_q, pending_d;
    logic [15:0]           read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  period_strobe_q, period_strobe_d;
    logic [ADDR_WIDTH-1:0] offset;
    reg_off_t              off;
    logic                  in_window, tick, wrap, wr, rd, fading;

    // Unsigned subtraction makes addresses below the base land far outside the window.
    assign offset    = i_address - BASE_ADDR;
    assign in_window = (offset >> 5) == '0;
    assign off       = offset[4:0];
    assign tick      = (ps_q == PS_W'(PRESCALE - 1));
    assign wrap      = tick && (count_q == '1);
    assign wr        = i_write_strobe && in_window;
    assign rd        = i_read_strobe && in_window;

    always_comb begin
        fading = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (current[i] != target_q[i]) fading = 1'b1;
        end
    end

    always_comb begin
        ps_d            = tick ? '0 : ps_q + PS_W'(1);
        count_d         = tick ? count_q + W'(1) : count_q;
        period_strobe_d = wrap;
        shadow_d        = shadow_q;
        target_d        = target_q;
        step_d          = step_q;
        enable_d        = enable_q;
        invert_d        = invert_q;
        pending_d       = pending_q;
        read_data_d     = read_data_q;
        read_valid_d    = 1'b0;

        // Commit uses the pre-write shadow; clearing precedes a same-cycle commit write
        // so that write stays pending for the following wrap.
        if (wrap && pending_q) begin
            target_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (wr) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (off == REG_DUTY0 + reg_off_t'(i)) shadow_d[i] = i_write_data[W-1:0];
            end
            case (off)
                REG_CTRL: begin
                    enable_d = i_write_data[CTRL_ENABLE];
                    invert_d = i_write_data[CTRL_INVERT];
                end
                REG_STEP:   step_d = i_write_data[W-1:0];
                REG_COMMIT: if (i_write_data[STAT_PENDING]) pending_d = 1'b1;
                default: ;
            endcase
        end

        if (rd) begin
            read_valid_d = 1'b1;
            read_data_d  = '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (off == REG_DUTY0 + reg_off_t'(i)) read_data_d = 16'(shadow_q[i]);
            end
            case (off)
                REG_CTRL: begin
                    read_data_d[CTRL_ENABLE] = enable_q;
                    read_data_d[CTRL_INVERT] = invert_q;
                end
                REG_STEP: read_data_d = 16'(step_q);
                REG_COMMIT: begin
                    read_data_d[STAT_PENDING] = pending_q;
                    read_data_d[STAT_FADING]  = fading;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ps_q            <= '0;
            count_q         <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= '0;
            end
            step_q          <= '0;
            enable_q        <= 1'b0;
            invert_q        <= 1'b0;
            pending_q       <= 1'b0;
            read_data_q     <= '0;
            read_valid_q    <= 1'b0;
            period_strobe_q <= 1'b0;
        end else begin
            ps_q            <= ps_d;
            count_q         <= count_d;
            shadow_q        <= shadow_d;
            target_q        <= target_d;
            step_q          <= step_d;
            enable_q        <= enable_d;
            invert_q        <= invert_d;
            pending_q       <= pending_d;
            read_data_q     <= read_data_d;
            read_valid_q    <= read_valid_d;
            period_strobe_q <= period_strobe_d;
        end
    end

    // Faders see the post-commit target so a step of 0 applies on the commit wrap itself.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        pwm_fader #(.PWM_WIDTH(W)) u_fader (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_wrap    (wrap),
            .i_step    (step_q),
            .i_target  (target_d[g]),
            .i_count   (count_q),
            .i_enable  (enable_q),
            .i_invert  (invert_q),
            .o_current (current[g]),
            .o_pwm     (o_pwm[g])
        );
    end

    assign o_read_data     = read_data_q;
    assign o_read_valid    = read_valid_q;
    assign o_period_strobe = period_strobe_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - randomized lockstep bench for pwm_bank against a behavioural model
module tb_pwm_bank;

    localparam int NCH  = 3;
    localparam int MAXC = 16;
    localparam int BASE = 'hE0;
    localparam int NCYC = 4000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_address = '0;
    logic [15:0] i_write_data = '0;
    logic        i_write_strobe = 1'b0;
    logic        i_read_strobe = 1'b0;
    logic [15:0] o_read_data;
    logic        o_read_valid;
    logic [2:0]  o_pwm;
    logic        o_period_strobe;

    pwm_bank #(
        .NUM_CHANNELS(3), .PWM_WIDTH(4), .PRESCALE(1), .ADDR_WIDTH(8), .BASE_ADDR(8'hE0)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_address(i_address),
        .i_write_data(i_write_data), .i_write_strobe(i_write_strobe),
        .i_read_strobe(i_read_strobe), .o_read_data(o_read_data),
        .o_read_valid(o_read_valid), .o_pwm(o_pwm), .o_period_strobe(o_period_strobe)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: plain integers advanced once per clock edge.
    int m_cnt, m_step, m_en, m_inv, m_pend;
    int m_shadow[NCH], m_target[NCH], m_cur[NCH];
    int e_pwm, e_strobe, e_rvalid, e_rdata;

    task automatic model_reset();
        m_cnt = 0; m_step = 0; m_en = 0; m_inv = 0; m_pend = 0;
        for (int n = 0; n < NCH; n++) begin
            m_shadow[n] = 0; m_target[n] = 0; m_cur[n] = 0;
        end
        e_pwm = 0; e_strobe = 0; e_rvalid = 0; e_rdata = 0;
    endtask

    function automatic int approach(int cur, int tgt, int step);
        if (step == 0) return tgt;
        if (cur < tgt) return (cur + step > tgt) ? tgt : cur + step;
        return (cur - step < tgt) ? tgt : cur - step;
    endfunction

    function automatic int model_read(int off);
        int fad = 0;
        for (int n = 0; n < NCH; n++) if (m_cur[n] != m_target[n]) fad = 1;
        if (off < NCH) return m_shadow[off];
        if (off == 16) return m_en + 2 * m_inv;
        if (off == 17) return m_step;
        if (off == 18) return m_pend + 2 * fad;
        return 0;
    endfunction

    task automatic model_step(input bit we, input bit re, input int addr, input int data);
        int off = addr - BASE;
        bit inwin = (off >= 0) && (off < 32);
        bit wrap = (m_cnt == MAXC - 1);
        int p = 0;
        for (int n = 0; n < NCH; n++)
            if (m_en != 0 && ((m_cnt < m_cur[n]) != (m_inv != 0))) p += (1 << n);
        e_pwm = p;
        e_strobe = wrap;
        e_rvalid = re && inwin;
        if (re && inwin) e_rdata = model_read(off);
        if (wrap) begin
            if (m_pend != 0) begin
                m_target = m_shadow;
                m_pend = 0;
            end
            for (int n = 0; n < NCH; n++) m_cur[n] = approach(m_cur[n], m_target[n], m_step);
        end
        if (we && inwin) begin
            if (off < NCH) m_shadow[off] = data % MAXC;
            else if (off == 16) begin m_en = data % 2; m_inv = (data / 2) % 2; end
            else if (off == 17) m_step = data % MAXC;
            else if (off == 18 && (data % 2) == 1) m_pend = 1;
        end
        m_cnt = (m_cnt + 1) % MAXC;
    endtask

    typedef struct {
        bit we; bit re; bit at_wrap; bit rst; int addr; int data;
    } op_t;
    op_t ops[$];

    task automatic push(input bit we, input bit re, input int addr, input int data,
                        input bit at_wrap = 1'b0);
        op_t o;
        o.we = we; o.re = re; o.at_wrap = at_wrap; o.rst = 1'b0; o.addr = addr; o.data = data;
        ops.push_back(o);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push(1'b0, 1'b0, 0, 0);
    endtask

    task automatic push_reset();
        op_t o;
        o.we = 0; o.re = 0; o.at_wrap = 0; o.rst = 1'b1; o.addr = 0; o.data = 0;
        ops.push_back(o);
    endtask

    function automatic op_t rand_op();
        op_t o;
        int addrs[10];
        addrs = '{'hE0, 'hE1, 'hE2, 'hF0, 'hF1, 'hF2, 'hE5, 'hFF, 'h10, 'hDF};
        o.at_wrap = 0; o.rst = 0; o.we = 0; o.re = 0; o.addr = 0; o.data = 0;
        if ($urandom_range(0, 99) < 75) return o;
        o.addr = addrs[$urandom_range(0, 9)];
        case ($urandom_range(0, 2))
            0: o.we = 1;
            1: o.re = 1;
            default: begin o.we = 1; o.re = 1; end
        endcase
        case (o.addr)
            'hE0, 'hE1, 'hE2: o.data = ($urandom_range(0, 3) == 0) ? 15 :
                                       ($urandom_range(0, 3) == 0) ? 0 :
                                       $urandom_range(0, 15) + 16 * $urandom_range(0, 3);
            'hF0: o.data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3)
                                                       : 1 + 2 * $urandom_range(0, 1);
            'hF1: o.data = $urandom_range(0, 6);
            'hF2: o.data = $urandom_range(0, 3);
            default: o.data = $urandom_range(0, 65535);
        endcase
        return o;
    endfunction

    initial begin
        op_t op;
        model_reset();

        push(1, 0, 'hF0, 1); push_idle(64);
        push(1, 0, 'hE0, 4); push(1, 0, 'hE1, 8); push(1, 0, 'hE2, 15);
        push(1, 0, 'hF1, 0); push(1, 0, 'hF2, 1); push(0, 1, 'hF2, 0);
        push_idle(20); push(0, 1, 'hF2, 0); push_idle(32);
        push(1, 0, 'hF1, 3); push(1, 0, 'hE0, 10); push(1, 0, 'hF2, 1);
        push_idle(40); push_reset();
        for (int a = 0; a < 3; a++) push(0, 1, 'hE0 + a, 0);
        for (int a = 0; a < 3; a++) push(0, 1, 'hF0 + a, 0);
        push(1, 0, 'hF0, 1); push(1, 0, 'hF1, 3); push(1, 0, 'hE0, 10); push(1, 0, 'hF2, 1);
        for (int k = 0; k < 6; k++) begin push_idle(15); push(0, 1, 'hF2, 0); end
        push(1, 0, 'hE0, 0); push(1, 0, 'hF2, 1);
        for (int k = 0; k < 6; k++) begin push_idle(15); push(0, 1, 'hF2, 0); end
        push(1, 0, 'hF1, 0); push(1, 0, 'hE0, 12); push_idle(48); push(1, 0, 'hF2, 1); push_idle(32);
        push(1, 0, 'hE0, 5); push(1, 0, 'hF2, 1); push(1, 0, 'hE0, 9, 1'b1);
        push(0, 1, 'hE0, 0); push(1, 0, 'hF0, 3); push_idle(40);
        push(1, 1, 'hE1, 7); push(0, 1, 'hE1, 0);
        push(0, 1, 'hE5, 0); push(0, 1, 'h10, 0); push(0, 1, 'hDF, 0);
        push(0, 1, 'hFF, 0); push(0, 1, 'hE3, 0); push_idle(4);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge i_clk);
            if (!i_rst_n) i_rst_n = 1'b1;
            check_eq("pwm", o_pwm, e_pwm);
            check_eq("period_strobe", o_period_strobe, e_strobe);
            check_eq("read_valid", o_read_valid, e_rvalid);
            check_eq("read_data", o_read_data, e_rdata);

            if (ops.size() > 0 && !(ops[0].at_wrap && m_cnt != MAXC - 1)) begin
                op = ops.pop_front();
            end else if (ops.size() > 0) begin
                op = '{default: 0};
            end else begin
                op = rand_op();
                if (cyc == NCYC - 300) op.rst = 1'b1;
            end

            if (op.rst) begin
                i_write_strobe = 1'b0; i_read_strobe = 1'b0;
                #2 i_rst_n = 1'b0;
                #1;
                check_eq("async_rst_pwm", o_pwm, 0);
                check_eq("async_rst_strobe", o_period_strobe, 0);
                check_eq("async_rst_valid", o_read_valid, 0);
                check_eq("async_rst_data", o_read_data, 0);
                model_reset();
                for (int a = 5; a >= 0; a--) begin
                    op_t r;
                    r.we = 0; r.re = 1; r.at_wrap = 0; r.rst = 0; r.data = 0;
                    r.addr = (a < 3) ? 'hE0 + a : 'hF0 + a - 3;
                    ops.push_front(r);
                end
                continue;
            end

            i_address = 8'(op.addr);
            i_write_data = 16'(op.data);
            i_write_strobe = op.we;
            i_read_strobe = op.re;
            model_step(op.we, op.re, op.addr, op.data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
Parametrised multi-channel LED PWM engine with its own register slice on the SPI register bus. It generalises the fixed three-channel RGB duty logic in top.v, adding:
- N channels of configurable counter width
- a clock prescaler
- shadow/commit double-buffering so all channels update together at a period boundary
- linear fading toward a target duty.

It sits between the spi register strobes and SB_RGBA_DRV (or plain GPIO) PWM inputs.

Parameters:
NUM_CHANNELS, 3, number of PWM outputs (1..16)
PWM_WIDTH, 16, duty/counter width in bits (4..16)
PRESCALE, 1, i_clk cycles per PWM counter increment (>=1)
ADDR_WIDTH, 8, register address width
BASE_ADDR, 8'hE0, first register address of this block's 32-word window

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_address  in  ADDR_WIDTH  register address from spi
i_write_data  in  16  write data
i_write_strobe  in  1  one-cycle register write strobe
i_read_strobe  in  1  one-cycle register read strobe
o_read_data  out  16  registered read data
o_read_valid  out  1  pulses one cycle after a read that hit the window
o_pwm  out  NUM_CHANNELS  registered PWM outputs
o_period_strobe  out  1  one-cycle pulse on PWM counter wrap

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - counters, shadow duties, target duties, current duties, step: 0
  - enable=0, invert=0, pending=0
  - o_pwm=0, o_read_data=0, o_read_valid=0, o_period_strobe=0
  - Reset mid-period or mid-fade discards all state.
- Register window, offset = i_address - BASE_ADDR, valid when 0 <= offset < 32:
  - 0x00..NUM_CHANNELS-1: shadow duty per channel, R/W, low PWM_WIDTH bits; upper read bits 0.
  - 0x10: control. bit0 enable, bit1 invert, R/W.
  - 0x11: fade step, R/W, PWM_WIDTH bits. 0 means targets apply instantly.
  - 0x12: write bit0=1 sets pending (commit request). Read: bit0 pending, bit1 fading (any current != target).
  - Other offsets in the window: writes ignored, reads return 0.
  - Reads outside the window: o_read_data holds its value and o_read_valid stays 0.
- Read latency is 1 cycle: o_read_data and o_read_valid are registered on the i_read_strobe cycle.
- Prescaler: tick every PRESCALE cycles. The PWM counter increments on each tick and wraps from 2^PWM_WIDTH-1 to 0.
- Wrap cycle: o_period_strobe=1 for one i_clk cycle.
- On wrap, if pending: target[n] <= shadow[n] for all channels simultaneously, and pending <= 0.
- On wrap, fading, for each channel with current != target:
  - step==0: current <= target.
  - otherwise current moves toward target by step, clamped to target with no overshoot and no wrap-around.
  - Width: compute in PWM_WIDTH+1 bits.
- Output: o_pwm[n] <= enable & ((counter < current[n]) ^ invert), registered one cycle after the counter.
  - Duty 0 gives always low; duty 2^W-1 gives high for 2^W-1 of 2^W ticks.
  - enable=0 forces 0 regardless of invert.
- Simultaneous events:
  - A write to a shadow register on a wrap-with-pending cycle: target takes the old shadow value; the shadow takes the new value.
  - A commit write on a wrap cycle: pending is set (or stays set) after that wrap and applies at the next wrap.
  - Read and write to the same address in one cycle: the read returns the pre-write value.
- Counter and prescaler run regardless of enable.

Decomposition:
- Shared package pwm_bank_pkg:
  - register offset localparams (REG_DUTY0, REG_CTRL, REG_STEP, REG_COMMIT)
  - control bit indices
- One natural sub-module: pwm_fader. It is per-channel, holds current duty, applies the clamped step on the wrap pulse, and generates the compare output. It is instantiated NUM_CHANNELS times via generate.

Test Plan:
Use PWM_WIDTH=4, PRESCALE=1, NUM_CHANNELS=3, BASE_ADDR=8'hE0 unless noted.
- Reset then enable only: with all duties 0, o_pwm stays 3'b000 for 64 cycles; o_period_strobe pulses every 16 cycles.
- Write E0=4, E1=8, E2=15; write F1=0; commit (F2=1); enable: after the next wrap, per 16-cycle period ch0 is high 4 cycles, ch1 8, ch2 15. F2 reads pending=1 before that wrap and 0 after.
- Fade: step=3, ch0 current 0, target 10 committed: current follows 0, 3, 6, 9, 10 on successive wraps. F2 bit1=1 until it reaches 10, then 0. Fading down 10 to 0 follows 10, 7, 4, 1, 0.
- Shadow isolation: write E0=12 without commit: output unchanged across 3 periods. After commit it changes only at the next wrap.
- Collision: write E0=9 and the wrap-with-pending (shadow was 5) in the same cycle: target=5, E0 reads 9. Invert=1 with duty 5 gives 11 high cycles per period.
- Reads and reset: a read of E5 (unmapped) returns 0 with valid; a read of 0x10 (outside window) gives no valid and holds data. Asserting i_rst_n=0 mid-fade clears o_pwm asynchronously and all registers read back 0.
